// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
// Holds the sequential divider state encoding, the default ALU operand width
// and the quotient pattern returned on a divide-by-zero.
package alu_pkg;

  // Default operand/result width of the ALU datapath.
  localparam int ALU_W = 8;

  // Widest divider that can be built; bounds the divide-by-zero constant.
  localparam int DIV_MAX_W = 16;

  // Quotient reported when the divisor is zero. Users slice the low WIDTH
  // bits, which are all ones for any legal width.
  localparam logic [DIV_MAX_W-1:0] DIV0_QUO = '1;

  // Sequential divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : alu_pkg

// File: rtl/div_step.sv
// div_step: one combinational iteration of an unsigned restoring divider.
// Shifts the next dividend bit (quo MSB) into the partial remainder and
// subtracts the divisor; the subtraction is kept only if it does not borrow.
// Ports:
//   rem_i    - partial remainder before this step
//   quo_i    - partially shifted dividend / quotient register
//   div_i    - divisor
//   rem_o    - partial remainder after this step
//   quo_o    - quotient register after this step (new bit in LSB)
//   borrow_o - 1 when the trial subtraction went negative (restore)
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o,
  output logic             borrow_o
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] diff;
  logic             carry;

  // Before step k the partial remainder is built from only k-1 dividend
  // bits, so its MSB is always zero and dropping it in the shift loses nothing.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_i[WIDTH-1];

  assign shifted = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};

  // shifted - div as shifted + ~div + 1; carry out set means no borrow.
  FAdder #(
    .W(WIDTH)
  ) u_sub (
    .a_i   (shifted),
    .b_i   (~div_i),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(carry)
  );

  assign borrow_o = ~carry;
  assign rem_o    = borrow_o ? shifted : diff;
  assign quo_o    = {quo_i[WIDTH-2:0], carry};

endmodule : div_step

// File: rtl/fadder.sv
// FAdder: W-bit binary adder with carry in and carry out.
// Ports:
//   a_i, b_i  - addends
//   cin_i     - carry in
//   sum_o     - W-bit sum
//   cout_o    - carry out of the top bit
module FAdder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule : FAdder

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider for the ALU datapath.
// A start pulse in IDLE or DONE captures first/second; WIDTH iteration edges
// later quotient/remainder are updated and done pulses for one cycle. A zero
// divisor completes on the accepting edge with errorWire set.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - operation request, ignored while busy
//   first       - dividend, second - divisor (captured on acceptance)
//   busy        - high while iterating
//   done        - one-cycle completion pulse
//   quotient    - registered quotient, held until the next completion
//   remainder   - registered remainder, held until the next completion
//   errorWire   - divide-by-zero flag, held with the results
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             errorWire
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             unused_step_borrow;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i   (rem_q),
    .quo_i   (quo_q),
    .div_i   (div_q),
    .rem_o   (step_rem),
    .quo_o   (step_quo),
    .borrow_o(unused_step_borrow)
  );

  // NOTE: every signal is given its hold value first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (second == '0) begin
            // Divide-by-zero finishes immediately without iterating.
            quotient_d  = DIV0_QUO[WIDTH-1:0];
            remainder_d = first;
            error_d     = 1'b1;
            state_d     = ST_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = first;
            div_d   = second;
            cnt_d   = '0;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          quotient_d  = step_quo;
          remainder_d = step_rem;
          error_d     = 1'b0;
          state_d     = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign errorWire = error_q;

endmodule : seq_divider
